// File: rtl/seg_marquee_pkg.sv
// Shared types and constants for the seg_marquee scrolling 7-segment driver.
// Segment byte layout (active-high, before inversion): bit7=a .. bit1=g, bit0=dp.
package seg_pkg;

  typedef enum logic [1:0] {
    SEG_HOLD     = 2'd0,
    SEG_SCROLL_L = 2'd1,
    SEG_SCROLL_R = 2'd2,
    SEG_BLINK    = 2'd3
  } seg_mode_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry n is the active-high pattern for hex digit n; dp bit is always 0 here.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/seg_marquee_if.sv
// Control/data bundle between the marquee driver and its controller.
// SEG_DP_EN: when defined, adds the per-nibble decimal-point input i_wr_dp.
interface seg_marquee_if
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned DIV_W    = 32
) ();

  logic                    i_wr_valid;
  logic [3:0]              i_wr_data;
`ifdef SEG_DP_EN
  logic                    i_wr_dp;
`endif
  logic                    o_wr_ready;
  logic                    i_clear;
  seg_mode_e               i_mode;
  logic [DIV_W-1:0]        i_period;
  logic                    o_tick;
  logic [8*N_DIGITS-1:0]   o_seg;

  modport master (
`ifdef SEG_DP_EN
    output i_wr_dp,
`endif
    output i_wr_valid, i_wr_data, i_clear, i_mode, i_period,
    input  o_wr_ready, o_tick, o_seg
  );

  modport slave (
`ifdef SEG_DP_EN
    input  i_wr_dp,
`endif
    input  i_wr_valid, i_wr_data, i_clear, i_mode, i_period,
    output o_wr_ready, o_tick, o_seg
  );

endinterface

// File: rtl/seg_tick_div.sv
// Programmable prescaler: registered one-cycle tick every i_period+1 cycles.
// The period is compared live, so a shorter period forces a tick on the next edge.
module seg_tick_div #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);

  logic [DIV_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // Next count: wrap to zero and tick once the period is reached or exceeded.
  always_comb begin
    count_d = count_q + DIV_W'(1);
    tick_d  = 1'b0;
    if (count_q >= i_period) begin
      count_d = '0;
      tick_d  = 1'b1;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/seg_marquee.sv
// Scrolling N-digit active-low 7-segment driver with a nibble message buffer.
// SEG_DP_EN: when defined, a decimal-point bit is stored with each nibble and
// lights bit0 of its digit; otherwise bit0 is always driven high (off).
module seg_marquee
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 8,
  parameter int unsigned BUF_DEPTH = 16,
  parameter int unsigned DIV_W     = 32
) (
  input logic          clk,
  input logic          rst,
  seg_marquee_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef logic [LEN_W-1:0] len_t;

  logic [3:0]            mem_q [BUF_DEPTH];
`ifdef SEG_DP_EN
  logic                  mem_dp_q [BUF_DEPTH];
`endif
  len_t                  len_q, len_d;
  len_t                  off_q, off_d;
  logic                  phase_q, phase_d;
  logic [8*N_DIGITS-1:0] seg_q, seg_d;
  logic                  tick;
  logic                  wr_ready;
  logic                  wr_en;
  logic                  blank;
  len_t                  idx;
  logic [7:0]            pat;

  seg_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk      (clk),
    .rst      (rst),
    .i_period (bus.i_period),
    .o_tick   (tick)
  );

  assign wr_ready = (len_q < len_t'(BUF_DEPTH)) && !bus.i_clear;
  assign wr_en    = bus.i_wr_valid && wr_ready;

  // Message storage; entries beyond len are stale and never displayed.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[len_q[PTR_W-1:0]] <= bus.i_wr_data;
`ifdef SEG_DP_EN
      mem_dp_q[len_q[PTR_W-1:0]] <= bus.i_wr_dp;
`endif
    end
  end

  // Length, window offset and blink phase; clear beats write and scroll.
  always_comb begin
    len_d   = len_q;
    off_d   = off_q;
    phase_d = phase_q;
    if (bus.i_clear) begin
      len_d = '0;
      off_d = '0;
    end else begin
      if (wr_en) len_d = len_q + len_t'(1);
      if (tick && (len_q != '0)) begin
        case (bus.i_mode)
          SEG_SCROLL_L: off_d = (off_q == len_q - len_t'(1)) ? '0 : off_q + len_t'(1);
          SEG_SCROLL_R: off_d = (off_q == '0) ? len_q - len_t'(1) : off_q - len_t'(1);
          default:      off_d = off_q;
        endcase
      end
    end
    if (bus.i_mode == SEG_BLINK) begin
      if (tick) phase_d = ~phase_q;
    end else begin
      phase_d = 1'b0;
    end
  end

  // Digit patterns; idx walks (offset+k) mod len with one wrap subtraction per step,
  // valid because offset<len keeps idx+1 <= len.
  always_comb begin
    seg_d = {N_DIGITS{SEG_BLANK}};
    blank = (len_q == '0) || ((bus.i_mode == SEG_BLINK) && phase_q);
    idx   = off_q;
    pat   = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!blank) begin
        pat = hex_to_seg(mem_q[idx[PTR_W-1:0]]);
`ifdef SEG_DP_EN
        pat[0] = mem_dp_q[idx[PTR_W-1:0]];
`else
        pat[0] = 1'b0;
`endif
        seg_d[8*k +: 8] = ~pat;
      end
      idx = idx + len_t'(1);
      if (idx >= len_q) idx = idx - len_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      off_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= {N_DIGITS{SEG_BLANK}};
    end else begin
      len_q   <= len_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.o_wr_ready = wr_ready;
  assign bus.o_tick     = tick;
  assign bus.o_seg      = seg_q;

endmodule
